// File: rtl/ras_ctrl.sv
// Call/return classifier feeding the return address stack; one-entry registered prediction.
// Optional compressed-jump decode is enabled by defining RAS_CTRL_RVC_EN.
module ras_ctrl #(
  parameter int unsigned VLEN = 64,
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [VLEN-1:0] pc_i,
  input  logic            ras_valid_i,
  input  logic [VLEN-1:0] ras_ra_i,
  output logic            ras_push_o,
  output logic            ras_pop_o,
  output logic [VLEN-1:0] ras_data_o,
  output logic            pred_valid_o,
  input  logic            pred_ready_i,
  output logic [1:0]      pred_type_o,
  output logic            pred_taken_o,
  output logic [VLEN-1:0] pred_target_o
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;
  typedef enum logic [1:0] {
    PredNone = 2'b00,
    PredCall = 2'b01,
    PredRet  = 2'b10,
    PredCoro = 2'b11
  } pred_e;

  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;

  state_e          state_q, state_d;
  pred_e           type_q, dec_type;
  logic            taken_q, dec_taken;
  logic [VLEN-1:0] target_q, dec_target;
  logic [VLEN-1:0] ret_addr_q, ret_addr_d;
  logic            full, accept, handshake;
  logic [4:0]      rd, rs1;
  logic [VLEN-1:0] j_imm;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  assign rd    = instr_i[11:7];
  assign rs1   = instr_i[19:15];
  assign j_imm = {{(VLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

`ifdef RAS_CTRL_RVC_EN
  logic            is_rvc;
  logic [VLEN-1:0] cj_imm;

  assign is_rvc = (instr_i[1:0] != 2'b11);
  assign cj_imm = {{(VLEN-11){instr_i[12]}}, instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                   instr_i[2], instr_i[11], instr_i[5:3], 1'b0};
  assign ret_addr_d = pc_i + (is_rvc ? VLEN'(2) : VLEN'(4));
`else
  assign ret_addr_d = pc_i + VLEN'(4);
`endif

  // Only JAL calls carry a static target; return/coroutine targets come from the stack later.
  always_comb begin
    dec_type   = PredNone;
    dec_taken  = 1'b0;
    dec_target = '0;
    if (instr_i[6:0] == OpJal) begin
      if (is_link(rd)) begin
        dec_type   = PredCall;
        dec_taken  = 1'b1;
        dec_target = pc_i + j_imm;
      end
    end else if (instr_i[6:0] == OpJalr && instr_i[14:12] == 3'b000) begin
      if (!is_link(rd) && is_link(rs1)) begin
        dec_type = PredRet;
      end else if (is_link(rd) && !is_link(rs1)) begin
        dec_type = PredCall;
      end else if (is_link(rd) && is_link(rs1)) begin
        dec_type = (rd == rs1) ? PredCall : PredCoro;
      end
    end
`ifdef RAS_CTRL_RVC_EN
    if (is_rvc) begin
      dec_type   = PredNone;
      dec_taken  = 1'b0;
      dec_target = '0;
      if (instr_i[1:0] == 2'b10 && instr_i[15:13] == 3'b100 && instr_i[6:2] == 5'd0 &&
          instr_i[11:7] != 5'd0) begin
        if (!instr_i[12]) begin
          if (is_link(instr_i[11:7])) dec_type = PredRet;
        end else begin
          // c.jalr links x1, so rs1 = x5 is the only coroutine form
          dec_type = (instr_i[11:7] == 5'd5) ? PredCoro : PredCall;
        end
      end else if (XLEN == 32 && instr_i[1:0] == 2'b01 && instr_i[15:13] == 3'b001) begin
        dec_type   = PredCall;
        dec_taken  = 1'b1;
        dec_target = pc_i + cj_imm;
      end
    end
`endif
  end

  assign full      = (state_q == StFull);
  assign accept    = instr_valid_i & instr_ready_o & ~flush_i;
  assign handshake = full & pred_ready_i & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = StFull;
    end else if (handshake) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      type_q     <= PredNone;
      taken_q    <= 1'b0;
      target_q   <= '0;
      ret_addr_q <= '0;
    end else if (accept) begin
      type_q     <= dec_type;
      taken_q    <= dec_taken;
      target_q   <= dec_target;
      ret_addr_q <= ret_addr_d;
    end
  end

  always_comb begin
    pred_valid_o  = full;
    instr_ready_o = ~full | pred_ready_i;
    pred_type_o   = full ? type_q : PredNone;
    pred_taken_o  = 1'b0;
    pred_target_o = '0;
    if (full) begin
      case (type_q)
        PredCall: begin
          pred_taken_o  = taken_q;
          pred_target_o = target_q;
        end
        PredRet, PredCoro: begin
          pred_taken_o  = ras_valid_i;
          pred_target_o = ras_ra_i;
        end
        default: ;
      endcase
    end
    ras_push_o = handshake & ((type_q == PredCall) | (type_q == PredCoro));
    ras_pop_o  = handshake & (((type_q == PredRet) & ras_valid_i) | (type_q == PredCoro));
    ras_data_o = full ? ret_addr_q : '0;
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: expectations queued at accept, compared at prediction handshake.
module tb_ras_ctrl;

  typedef struct {
    logic [1:0]  typ;
    logic        taken;
    logic [63:0] target;
    logic        push;
    logic        pop;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, instr_valid_i, instr_ready_o;
  logic [31:0] instr_i;
  logic [63:0] pc_i;
  logic        ras_valid_i;
  logic [63:0] ras_ra_i;
  logic        ras_push_o, ras_pop_o;
  logic [63:0] ras_data_o;
  logic        pred_valid_o, pred_ready_i;
  logic [1:0]  pred_type_o;
  logic        pred_taken_o;
  logic [63:0] pred_target_o;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   first_acc = 0;
  exp_t sb[$];
  exp_t got_e;

  ras_ctrl #(.VLEN(64), .XLEN(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush_i),
    .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o),
    .instr_i      (instr_i),
    .pc_i         (pc_i),
    .ras_valid_i  (ras_valid_i),
    .ras_ra_i     (ras_ra_i),
    .ras_push_o   (ras_push_o),
    .ras_pop_o    (ras_pop_o),
    .ras_data_o   (ras_data_o),
    .pred_valid_o (pred_valid_o),
    .pred_ready_i (pred_ready_i),
    .pred_type_o  (pred_type_o),
    .pred_taken_o (pred_taken_o),
    .pred_target_o(pred_target_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] t, input logic tk, input logic [63:0] tg,
                              input logic pu, input logic po, input logic [63:0] d);
    exp_t e;
    e.typ = t; e.taken = tk; e.target = tg; e.push = pu; e.pop = po; e.data = d;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [63:0] pc, input exp_t e,
                      input bit expect_out);
    bit ok = 1'b0;
    instr_i = ins;
    pc_i = pc;
    instr_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_ready_o && !flush_i && !rst) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", 64'(ok), 64'd1);
    acc_cyc = cyc;
    if (ok && expect_out) sb.push_back(e);
    @(posedge clk);
    #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic one(input logic [31:0] ins, input logic [63:0] pc, input exp_t e);
    send(ins, pc, e, 1'b1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && pred_valid_o) begin
      if (pred_ready_i && !flush_i) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          got_e = sb.pop_front();
          check("pred_type", 64'(pred_type_o), 64'(got_e.typ));
          check("pred_taken", 64'(pred_taken_o), 64'(got_e.taken));
          check("pred_target", pred_target_o, got_e.target);
          check("ras_push", 64'(ras_push_o), 64'(got_e.push));
          check("ras_pop", 64'(ras_pop_o), 64'(got_e.pop));
          check("ras_data", ras_data_o, got_e.data);
        end
      end else begin
        check("hold_push", 64'(ras_push_o), 64'd0);
        check("hold_pop", 64'(ras_pop_o), 64'd0);
      end
    end else if (!rst) begin
      check("idle_data", ras_data_o, 64'd0);
      check("idle_strobe", 64'({ras_push_o, ras_pop_o}), 64'd0);
    end
  end

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    instr_valid_i = 1'b0;
    instr_i = '0;
    pc_i = '0;
    ras_valid_i = 1'b0;
    ras_ra_i = '0;
    pred_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pred_valid", 64'(pred_valid_o), 64'd0);
    check("rst_ready", 64'(instr_ready_o), 64'd1);
    check("rst_strobes", 64'({ras_push_o, ras_pop_o}), 64'd0);
    check("rst_data", ras_data_o, 64'd0);
    check("rst_pred", {61'd0, pred_type_o, pred_taken_o}, 64'd0);
    check("rst_target", pred_target_o, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // JAL x1,+0x100
    one(32'h1000_00EF, 64'h8000_0000, mk(2'b01, 1'b1, 64'h8000_0100, 1'b1, 1'b0, 64'h8000_0004));
    // JALR x0,0(x1) with and without a valid top of stack
    ras_valid_i = 1'b1;
    ras_ra_i = 64'h8000_0004;
    one(32'h0000_8067, 64'h8000_0100, mk(2'b10, 1'b1, 64'h8000_0004, 1'b0, 1'b1, 64'h8000_0104));
    ras_valid_i = 1'b0;
    one(32'h0000_8067, 64'h8000_0100, mk(2'b10, 1'b0, 64'h8000_0004, 1'b0, 1'b0, 64'h8000_0104));
    // JALR x1,0(x5): coroutine
    ras_valid_i = 1'b1;
    ras_ra_i = 64'h5550;
    one(32'h0002_80E7, 64'h100, mk(2'b11, 1'b1, 64'h5550, 1'b1, 1'b1, 64'h104));
    // JALR x5,0(x5) and JALR x1,0(x1): calls, not taken
    one(32'h0002_82E7, 64'h200, mk(2'b01, 1'b0, 64'h0, 1'b1, 1'b0, 64'h204));
    one(32'h0000_80E7, 64'h300, mk(2'b01, 1'b0, 64'h0, 1'b1, 1'b0, 64'h304));
    // JALR x0,0(x6), JAL x0, ADDI: none
    one(32'h0003_0067, 64'h400, mk(2'b00, 1'b0, 64'h0, 1'b0, 1'b0, 64'h404));
    one(32'h1000_006F, 64'h500, mk(2'b00, 1'b0, 64'h0, 1'b0, 1'b0, 64'h504));
    one(32'h0010_0093, 64'h600, mk(2'b00, 1'b0, 64'h0, 1'b0, 1'b0, 64'h604));
    // JAL x5,-4
    one(32'hFFDF_F2EF, 64'h2000, mk(2'b01, 1'b1, 64'h1FFC, 1'b1, 1'b0, 64'h2004));
    // c.jr x1
    ras_ra_i = 64'h1234;
`ifdef RAS_CTRL_RVC_EN
    one(32'h0000_8082, 64'h1002, mk(2'b10, 1'b1, 64'h1234, 1'b0, 1'b1, 64'h1004));
`else
    one(32'h0000_8082, 64'h1002, mk(2'b00, 1'b0, 64'h0, 1'b0, 1'b0, 64'h1006));
`endif

    // Call stalled three cycles; push only in the handshake cycle
    pred_ready_i = 1'b0;
    send(32'h1000_00EF, 64'h3000, mk(2'b01, 1'b1, 64'h3100, 1'b1, 1'b0, 64'h3004), 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", 64'(instr_ready_o), 64'd0);
      check("stall_target", pred_target_o, 64'h3100);
    end
    @(posedge clk);
    #1;
    pred_ready_i = 1'b1;
    @(posedge clk);
    #1;

    // Stalled return, then flush with a competing handshake and new instruction
    pred_ready_i = 1'b0;
    ras_valid_i = 1'b1;
    ras_ra_i = 64'h4444;
    send(32'h0000_8067, 64'h500, mk(2'b10, 1'b1, 64'h4444, 1'b0, 1'b1, 64'h504), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    instr_i = 32'h0010_0093;
    pc_i = 64'h600;
    instr_valid_i = 1'b1;
    flush_i = 1'b1;
    pred_ready_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    instr_valid_i = 1'b0;
    check("flush_pred_valid", 64'(pred_valid_o), 64'd0);
    one(32'h0010_0093, 64'h600, mk(2'b00, 1'b0, 64'h0, 1'b0, 1'b0, 64'h604));

    // Back-to-back calls at full rate
    for (int i = 0; i < 4; i++) begin
      logic [63:0] p;
      p = 64'h4000 + 64'(i * 16);
      send(32'h1000_00EF, p, mk(2'b01, 1'b1, p + 64'h100, 1'b1, 1'b0, p + 64'h4), 1'b1);
      if (i == 0) first_acc = acc_cyc;
    end
    check("throughput", 64'(acc_cyc - first_acc), 64'd3);
    @(posedge clk);
    #1;

    // Reset while a call is stalled: dropped with no strobe
    pred_ready_i = 1'b0;
    send(32'h1000_00EF, 64'h7000, mk(2'b01, 1'b1, 64'h7100, 1'b1, 1'b0, 64'h7004), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(pred_valid_o), 64'd0);
    check("rst_mid_strobes", 64'({ras_push_o, ras_pop_o}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pred_ready_i = 1'b1;
    one(32'h0010_0093, 64'h800, mk(2'b00, 1'b0, 64'h0, 1'b0, 1'b0, 64'h804));

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
